// File: rtl/lpddr5_bank_responder.sv
// lpddr5_bank_responder: DRAM-side command responder with per-bank timing FSMs, violation flagging and RL-latency read data
// Ports: clk/rst (sync, active-high); cmd_valid/cmd/cmd_bank/cmd_col/wr_data command bus in;
//        rd_valid/rd_data read return; err/err_code protocol error; bank_state packed per bank; busy any bank transient.
module lpddr5_bank_responder #(
    parameter int NUM_BANKS = 4,
    parameter int COL_AW    = 4,
    parameter int DATA_W    = 32,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 8,
    parameter int T_BURST   = 2,
    parameter int RL        = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd,
    input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    input  logic [COL_AW-1:0]            cmd_col,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [3*NUM_BANKS-1:0]       bank_state,
    output logic                         busy
);
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int AW   = BW + COL_AW;
    localparam int TM1  = T_RCD > T_RP ? T_RCD : T_RP;
    localparam int TM2  = T_RFC > T_BURST ? T_RFC : T_BURST;
    localparam int TMAX = TM1 > TM2 ? TM1 : TM2;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3,
        CMD_PRE = 3'd4, CMD_REF = 3'd5, CMD_RSV = 3'd6, CMD_ERR = 3'd7
    } dram_cmd_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0, ACTIVATING = 3'd1, ACTIVE = 3'd2, READING = 3'd3,
        WRITING = 3'd4, PRECHARGING = 3'd5, REFRESHING = 3'd6
    } bank_state_t;

    bank_state_t       bs_q [NUM_BANKS];
    bank_state_t       bs_d [NUM_BANKS];
    logic [TW-1:0]     tmr_q [NUM_BANKS];
    logic [TW-1:0]     tmr_d [NUM_BANKS];
    logic [DATA_W-1:0] mem [2**AW];
    logic [RL-1:0]     pv;
    logic [DATA_W-1:0] pd [RL];
    dram_cmd_t         op;
    bank_state_t       tgt;
    logic              all_idle, bad_enc, ref_bad, st_bad, acc;

    // Command legality against the current state of the addressed bank
    always_comb begin
        op       = dram_cmd_t'(cmd);
        tgt      = bs_q[cmd_bank];
        all_idle = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++)
            all_idle = all_idle && (bs_q[b] == IDLE);
        bad_enc = cmd_valid && (cmd[2:1] == 2'b11);
        ref_bad = cmd_valid && (op == CMD_REF) && !all_idle;
        st_bad  = cmd_valid && ((op == CMD_ACT) ? (tgt != IDLE) :
                                (op == CMD_RD || op == CMD_WR) ? (tgt != ACTIVE) :
                                (op == CMD_PRE) ? !(tgt inside {IDLE, ACTIVE}) : 1'b0);
        acc     = cmd_valid && !bad_enc && !ref_bad && !st_bad;
    end

    // Bank FSM: state register
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rst) begin
                bs_q[b]  <= IDLE;
                tmr_q[b] <= '0;
            end else begin
                bs_q[b]  <= bs_d[b];
                tmr_q[b] <= tmr_d[b];
            end
        end
    end

    // Bank FSM: next state. Timers load T-1 so the new stable state appears exactly T cycles after accept.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bs_d[b]  = bs_q[b];
            tmr_d[b] = tmr_q[b];
            if (!(bs_q[b] inside {IDLE, ACTIVE})) begin
                if (tmr_q[b] <= TW'(1)) begin
                    if (bs_q[b] == PRECHARGING || bs_q[b] == REFRESHING) bs_d[b] = IDLE;
                    else bs_d[b] = ACTIVE;
                    tmr_d[b] = '0;
                end else begin
                    tmr_d[b] = tmr_q[b] - 1'b1;
                end
            end
            if (acc && op == CMD_REF) begin
                bs_d[b]  = REFRESHING;
                tmr_d[b] = TW'(T_RFC - 1);
            end else if (acc && cmd_bank == BW'(b)) begin
                if (op == CMD_ACT) begin
                    bs_d[b]  = ACTIVATING;
                    tmr_d[b] = TW'(T_RCD - 1);
                end else if (op == CMD_RD) begin
                    bs_d[b]  = READING;
                    tmr_d[b] = TW'(T_BURST - 1);
                end else if (op == CMD_WR) begin
                    bs_d[b]  = WRITING;
                    tmr_d[b] = TW'(T_BURST - 1);
                end else if (op == CMD_PRE && bs_q[b] == ACTIVE) begin
                    bs_d[b]  = PRECHARGING;
                    tmr_d[b] = TW'(T_RP - 1);
                end
            end
        end
    end

    // Bank FSM: outputs
    always_comb begin
        bank_state = '0;
        busy       = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_state[3*b +: 3] = bs_q[b];
            busy = busy || !(bs_q[b] inside {IDLE, ACTIVE});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc && op == CMD_WR) mem[{cmd_bank, cmd_col}] <= wr_data;
    end

    // Read pipeline: the last data stage only loads on a valid, so rd_data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            pv       <= '0;
            for (int k = 0; k < RL; k++) pd[k] <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            for (int k = RL - 1; k > 0; k--) begin
                pv[k] <= pv[k-1];
                if (k < RL - 1 || pv[k-1]) pd[k] <= pd[k-1];
            end
            pv[0] <= acc && op == CMD_RD;
            if (RL > 1 || (acc && op == CMD_RD)) pd[0] <= mem[{cmd_bank, cmd_col}];
            err <= bad_enc || ref_bad || st_bad;
            if (bad_enc || ref_bad || st_bad) err_code <= bad_enc ? 2'd2 : ref_bad ? 2'd3 : 2'd1;
        end
    end

    assign rd_valid = pv[RL-1];
    assign rd_data  = pd[RL-1];
endmodule

// File: tb/tb_lpddr5_bank_responder.sv
// tb_lpddr5_bank_responder: scenario tasks with inline checks plus a read-data scoreboard for lpddr5_bank_responder
module tb_lpddr5_bank_responder;
    localparam int RL = 3;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;
    localparam logic [2:0] S_IDLE = 3'd0, S_ACTG = 3'd1, S_ACT = 3'd2, S_RDG = 3'd3, S_WRG = 3'd4, S_PRE = 3'd5, S_REF = 3'd6;

    logic        clk = 0, rst = 1, cmd_valid = 0;
    logic [2:0]  cmd = 0;
    logic [1:0]  cmd_bank = 0;
    logic [3:0]  cmd_col = 0;
    logic [31:0] wr_data = 0;
    logic        rd_valid, err, busy;
    logic [31:0] rd_data;
    logic [1:0]  err_code;
    logic [11:0] bank_state;

    typedef struct { logic [31:0] d; int due; } rd_exp_t;
    rd_exp_t     exp_q[$];
    logic [31:0] mdl [64];
    int          cyc = 0, n_checks = 0, n_fail = 0;

    lpddr5_bank_responder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_col(cmd_col), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .err_code(err_code), .bank_state(bank_state), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every rd_valid must match the oldest outstanding read, on its due cycle
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rd_unexpected: rd_valid=1 data=%h at cyc %0d, expected no read", rd_data, cyc);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.d || cyc != e.due) begin
                    n_fail++; $display("FAIL rd_data: got %h at cyc %0d, expected %h at cyc %0d", rd_data, cyc, e.d, e.due);
                end
            end
        end
    end

    function automatic logic [2:0] st(input int b);
        return bank_state[3*b +: 3];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [2:0] c, input int b = 0, input int col = 0, input logic [31:0] d = 0);
        logic [5:0] a;
        a = 6'(b * 16 + col);
        cmd = c; cmd_bank = a[5:4]; cmd_col = a[3:0]; wr_data = d; cmd_valid = 1;
        tick();
        cmd_valid = 0; cmd = NOP;
    endtask

    task automatic do_rd(input int b, input int col);
        issue(RD, b, col);
        exp_q.push_back('{mdl[b*16+col], cyc + RL - 1});
    endtask

    task automatic do_wr(input int b, input int col, input logic [31:0] d);
        issue(WR, b, col, d);
        mdl[b*16+col] = d;
    endtask

    task automatic test_reset();
        rst = 1;
        ticks(2);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d expected 0/0", err, err_code); end
        n_checks++; if (bank_state !== 12'h000 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %h busy %b expected 000 busy 0", bank_state, busy); end
        rst = 0;
        tick();
    endtask

    task automatic test_act_read();
        issue(ACT, 0); ticks(3);
        do_wr(0, 5, 32'h1234_5678); tick();
        issue(PRE, 0); ticks(2);
        n_checks++; if (st(0) !== S_IDLE) begin n_fail++; $display("FAIL pre_b0_idle: got %0d expected %0d", st(0), S_IDLE); end
        issue(ACT, 0);
        n_checks++; if (st(0) !== S_ACTG || busy !== 1'b1) begin n_fail++; $display("FAIL act_t1: got %0d busy %b expected %0d busy 1", st(0), busy, S_ACTG); end
        ticks(2);
        n_checks++; if (st(0) !== S_ACTG) begin n_fail++; $display("FAIL act_t3: got %0d expected %0d", st(0), S_ACTG); end
        tick();
        n_checks++; if (st(0) !== S_ACT || busy !== 1'b0) begin n_fail++; $display("FAIL act_t4: got %0d busy %b expected %0d busy 0", st(0), busy, S_ACT); end
        do_rd(0, 5);
        n_checks++; if (st(0) !== S_RDG || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_t5: got %0d rv %b expected %0d rv 0", st(0), rd_valid, S_RDG); end
        tick();
        n_checks++; if (st(0) !== S_ACT || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_t6: got %0d rv %b expected %0d rv 0", st(0), rd_valid, S_ACT); end
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_t7: got rv %b %h expected rv 1 12345678", rd_valid, rd_data); end
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_t8: got rv %b %h expected rv 0 12345678 held", rd_valid, rd_data); end
        issue(PRE, 0); ticks(2);
    endtask

    task automatic test_write_read();
        issue(ACT, 1); ticks(3);
        do_wr(1, 3, 32'hDEAD_BEEF);
        n_checks++; if (st(1) !== S_WRG) begin n_fail++; $display("FAIL wr_state: got %0d expected %0d", st(1), S_WRG); end
        tick();
        do_rd(1, 3); ticks(3);
        issue(PRE, 1);
        n_checks++; if (st(1) !== S_PRE) begin n_fail++; $display("FAIL pre_state: got %0d expected %0d", st(1), S_PRE); end
        tick();
        n_checks++; if (st(1) !== S_PRE) begin n_fail++; $display("FAIL pre_t2: got %0d expected %0d", st(1), S_PRE); end
        tick();
        n_checks++; if (st(1) !== S_IDLE) begin n_fail++; $display("FAIL pre_t3: got %0d expected %0d", st(1), S_IDLE); end
    endtask

    task automatic test_early_rd();
        issue(ACT, 2); ticks(2);
        issue(RD, 2, 1);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL early_rd_err: got %b/%0d expected 1/1", err, err_code); end
        n_checks++; if (bank_state !== 12'h080) begin n_fail++; $display("FAIL early_rd_state: got %h expected 080", bank_state); end
        tick();
        n_checks++; if (err !== 1'b0 || err_code !== 2'd1) begin n_fail++; $display("FAIL early_rd_pulse: got %b/%0d expected 0/1", err, err_code); end
        issue(PRE, 2); ticks(3);
    endtask

    task automatic test_refresh();
        issue(REF);
        n_checks++; if (bank_state !== {4{S_REF}} || busy !== 1'b1) begin n_fail++; $display("FAIL ref_t1: got %h busy %b expected %h busy 1", bank_state, busy, {4{S_REF}}); end
        ticks(6);
        n_checks++; if (bank_state !== {4{S_REF}}) begin n_fail++; $display("FAIL ref_t7: got %h expected %h", bank_state, {4{S_REF}}); end
        tick();
        n_checks++; if (bank_state !== 12'h000 || busy !== 1'b0) begin n_fail++; $display("FAIL ref_t8: got %h busy %b expected 000 busy 0", bank_state, busy); end
        issue(ACT, 0); ticks(3);
        issue(REF);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd3) begin n_fail++; $display("FAIL ref_busy_err: got %b/%0d expected 1/3", err, err_code); end
        n_checks++; if (bank_state !== 12'h002) begin n_fail++; $display("FAIL ref_busy_state: got %h expected 002", bank_state); end
        issue(PRE, 0); ticks(2);
    endtask

    task automatic test_bad_enc();
        issue(3'b111);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL enc7_err: got %b/%0d expected 1/2", err, err_code); end
        tick();
        n_checks++; if (err !== 1'b0 || err_code !== 2'd2) begin n_fail++; $display("FAIL enc7_pulse: got %b/%0d expected 0/2", err, err_code); end
        issue(RD, 0, 0);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL idle_rd_err: got %b/%0d expected 1/1", err, err_code); end
        issue(3'b110);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL enc6_err: got %b/%0d expected 1/2", err, err_code); end
        tick();
        n_checks++; if (err !== 1'b0 || bank_state !== 12'h000) begin n_fail++; $display("FAIL enc6_pulse: got %b state %h expected 0 state 000", err, bank_state); end
    endtask

    task automatic test_back_to_back();
        issue(ACT, 0); issue(ACT, 1); ticks(3);
        do_wr(0, 1, 32'hAAAA_0001); do_wr(1, 2, 32'hBBBB_0002); tick();
        do_rd(0, 1); do_rd(1, 2);
        do_wr(0, 1, 32'hCCCC_0003);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", err); end
        ticks(4);
        do_rd(0, 1); ticks(4);
        issue(PRE, 0); issue(PRE, 1); ticks(3);
    endtask

    task automatic test_reset_mid();
        issue(ACT, 3); ticks(3);
        do_wr(3, 0, 32'h5555_AAAA); tick();
        issue(RD, 3, 0);
        rst = 1;
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_t2: got rv %b %h err %b expected 0 0 0", rd_valid, rd_data, err); end
        n_checks++; if (bank_state !== 12'h000 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got %h busy %b expected 000 busy 0", bank_state, busy); end
        rst = 0;
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_t3: got rv %b expected 0", rd_valid); end
        ticks(3);
    endtask

    initial begin
        test_reset();
        test_act_read();
        test_write_read();
        test_early_rd();
        test_refresh();
        test_bad_enc();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rd_outstanding: got %0d reads never returned, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
